// File: rtl/bcd_disp_pkg.sv
// Shared types and glyph/anode constants for the multiplexed 3-digit BCD display.
package bcd_disp_pkg;

  localparam int unsigned NUM_DIGITS = 3;

  typedef enum logic [1:0] {
    DIG_ONES = 2'd0,
    DIG_TENS = 2'd1,
    DIG_HUND = 2'd2
  } dig_idx_e;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low digit enables, bit order {hund,tens,ones}
  localparam logic [2:0] AN_OFF  = 3'b111;
  localparam logic [2:0] AN_ONES = 3'b110;
  localparam logic [2:0] AN_TENS = 3'b101;
  localparam logic [2:0] AN_HUND = 3'b011;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment decoder with blanking;
// any code above 9 renders as "E".
module bcd_to_seg7
  import bcd_disp_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  output logic [6:0] o_seg_n
);

  always_comb begin
    o_seg_n = SEG_E;
    if (i_blank) begin
      o_seg_n = SEG_BLANK;
    end else begin
      case (i_digit)
        4'd0:    o_seg_n = SEG_0;
        4'd1:    o_seg_n = SEG_1;
        4'd2:    o_seg_n = SEG_2;
        4'd3:    o_seg_n = SEG_3;
        4'd4:    o_seg_n = SEG_4;
        4'd5:    o_seg_n = SEG_5;
        4'd6:    o_seg_n = SEG_6;
        4'd7:    o_seg_n = SEG_7;
        4'd8:    o_seg_n = SEG_8;
        4'd9:    o_seg_n = SEG_9;
        default: o_seg_n = SEG_E;
      endcase
    end
  end

endmodule

// File: rtl/bcd_seg_scan_driver.sv
// Time-multiplexed 3-digit common-anode driver; BCD input is latched once per
// frame into a shadow register so a frame never mixes two values.
module bcd_seg_scan_driver
  import bcd_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000,
  parameter bit          LZB      = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] bcd_in,
  output logic [6:0] seg_n,
  output logic [2:0] an_n,
  output logic       frame_done
);

  localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

  logic [PW-1:0] r_presc;
  dig_idx_e      r_idx;
  dig_idx_e      w_idx_nxt;
  logic [9:0]    r_shadow;
  logic [6:0]    r_seg_n;
  logic [2:0]    r_an_n;
  logic          r_frame_done;

  logic          w_tick;
  logic          w_last;
  logic          w_reload;
  logic [1:0]    w_hund;
  logic [3:0]    w_tens;
  logic [3:0]    w_ones;
  logic [3:0]    w_digit;
  logic          w_blank;
  logic [2:0]    w_an;
  logic [6:0]    w_seg;

  assign w_tick   = (r_presc == PRESC_MAX);
  assign w_last   = (r_idx == dig_idx_e'(2'(NUM_DIGITS - 1)));
  assign w_reload = w_tick && w_last;

  assign w_hund = r_shadow[9:8];
  assign w_tens = r_shadow[7:4];
  assign w_ones = r_shadow[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= DIG_ONES;
    end else begin
      r_idx <= w_idx_nxt;
    end
  end

  always_comb begin
    w_idx_nxt = r_idx;
    if (w_tick) begin
      case (r_idx)
        DIG_ONES: w_idx_nxt = DIG_TENS;
        DIG_TENS: w_idx_nxt = DIG_HUND;
        default:  w_idx_nxt = DIG_ONES;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow     <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_reload;
      if (w_reload) begin
        r_shadow <= bcd_in;
      end
    end
  end

  // Hundreds==3 is forced to an out-of-range code so the decoder shows "E".
  always_comb begin
    w_digit = '0;
    w_blank = 1'b0;
    w_an    = AN_OFF;
    case (r_idx)
      DIG_ONES: begin
        w_digit = w_ones;
        w_an    = AN_ONES;
      end
      DIG_TENS: begin
        w_digit = w_tens;
        w_blank = LZB && (w_hund == 2'd0) && (w_tens == 4'd0);
        w_an    = AN_TENS;
      end
      DIG_HUND: begin
        w_digit = (w_hund == 2'd3) ? 4'hF : {2'b00, w_hund};
        w_blank = LZB && (w_hund == 2'd0);
        w_an    = AN_HUND;
      end
      default: begin
        w_blank = 1'b1;
      end
    endcase
    if (w_blank) begin
      w_an = AN_OFF;
    end
  end

  bcd_to_seg7 u_dec (
    .i_digit (w_digit),
    .i_blank (w_blank),
    .o_seg_n (w_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_n <= SEG_BLANK;
      r_an_n  <= AN_OFF;
    end else begin
      r_seg_n <= w_seg;
      r_an_n  <= w_an;
    end
  end

  assign seg_n      = r_seg_n;
  assign an_n       = r_an_n;
  assign frame_done = r_frame_done;

endmodule

// File: doc/bcd_seg_scan_driver.md
Name: bcd_seg_scan_driver

Overview:
- Downstream display stage for the 8-bit binary-to-BCD converter. Consumes its 10-bit packed BCD result: hundreds[9:8], tens[7:4], ones[3:0].
- Drives a 3-digit, common-anode, time-multiplexed 7-segment display.
- Samples the BCD input once per scan frame, so digits never tear mid-frame.
- Blanks leading zeros and flags invalid digit codes with an "E" glyph.

Parameters:
- SCAN_DIV, 100000: clock cycles per digit slot. Legal range is 2 or more. Benches use 4.
- LZB, 1: 1 enables leading-zero blanking; 0 always shows all three digits.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- bcd_in  input  10  packed BCD from the converter {hund[1:0], tens[3:0], ones[3:0]}
- seg_n  output  7  segments {g,f,e,d,c,b,a}, active-low, registered
- an_n  output  3  digit enables {hund,tens,ones}, active-low one-hot or all-off, registered
- frame_done  output  1  one-cycle pulse when the shadow register reloads, registered

Behaviour:
- Reset (async assert, sync release by the system): prescaler=0, digit index=0 (ones), shadow=0, seg_n=7'h7F, an_n=3'b111, frame_done=0.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - tick is asserted while prescaler==SCAN_DIV-1.
- Digit index:
  - Sequence 0 (ones) -> 1 (tens) -> 2 (hundreds) -> 0. Advances only on tick.
- Frame reload:
  - On tick with index==2: shadow <= bcd_in, index <= 0, frame_done <= 1 for the next cycle only.
  - frame_done is 0 at all other times.
  - bcd_in changes mid-frame are ignored until the next reload.
- Output registers:
  - Every cycle, seg_n/an_n are loaded from the current index and the current shadow. Outputs therefore lag the index by 1 cycle.
  - The first new-frame digit appears 1 cycle after the reload edge.
- Digit selection: index 0 -> an_n=3'b110; index 1 -> 3'b101; index 2 -> 3'b011.
- Segment codes (seg_n hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Invalid code (tens/ones>9 or hundreds==3) -> E=06.
  - Blank -> 7F.
- Leading-zero blanking (LZB=1):
  - Hundreds is blanked when hund==0.
  - Tens is blanked when hund==0 and tens==0.
  - Ones is never blanked.
  - A blanked slot drives seg_n=7F and an_n=3'b111; the slot time is still consumed, so the scan period is constant.
  - Invalid digits are never blanked; they show E.
- Frame period: exactly 3*SCAN_DIV cycles. Digit slot length: exactly SCAN_DIV cycles.
- Reset mid-frame: all state returns to reset values immediately. After release the scan restarts at ones, showing shadow=0, i.e. "0" with LZB on.
- No combinational path from bcd_in to any output.

Decomposition:
- Package bcd_disp_pkg:
  - NUM_DIGITS=3.
  - Digit index encodings DIG_ONES/DIG_TENS/DIG_HUND.
  - Segment constants SEG_0..SEG_9, SEG_E, SEG_BLANK.
  - Anode constants AN_OFF, AN_ONES, AN_TENS, AN_HUND.
- Sub-module bcd_to_seg7: purely combinational 4-bit digit plus blank flag to seg_n. It is instantiated once, after the digit mux.
- Prescaler, index, shadow, blanking logic and output registers stay in the top module.

Test Plan (SCAN_DIV=4, LZB=1 unless stated):
- Reset hold for 10 cycles -> seg_n=7F, an_n=111, frame_done=0. After release -> an_n=110, seg_n=40, then tens/hundreds slots with an_n=111.
- bcd_in=10'b01_0110_0101 (165), held one full frame -> after the frame_done pulse, a 12-cycle frame shows 110/12 ×4 cycles, 101/02 ×4, 011/79 ×4.
- bcd_in=10'b10_0100_0000 (240) -> frame shows 110/40, 101/19, 011/24. Zero ones digit is displayed, not blanked.
- bcd_in=10'b00_0000_0111 (7) -> 110/78, then 8 cycles of an_n=111, seg_n=7F. Repeat with LZB=0 -> 101/40 and 011/40 are shown.
- Change bcd_in from 165 to 240 mid-frame (during the tens slot) -> the current frame still shows 1,6,5. 240 appears only after the next frame_done pulse. frame_done pulses every 12 cycles.
- Inject tens=4'hA, ones=4'h3, hund=2'b11 -> digits show 30, 06, 06 (E, not blanked). Assert rst_n=0 mid-slot -> outputs go to 7F/111 asynchronously, before the next clock edge.
